// File: rtl/ps2_host_ctrl_pkg.sv
// Shared types and byte constants for the PS/2 host command path.
// Frame helper builds the 10-bit host-to-device payload shifted out after the start bit.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACKBIT,
    WAIT_RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NACK    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_NOACK   = 2'd3
  } status_t;

  localparam logic [7:0] ACK       = 8'hFA;
  localparam logic [7:0] RESEND    = 8'hFE;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_LEDS  = 8'hED;

  // {stop, odd parity, data}; bit 0 goes out first
  function automatic logic [9:0] tx_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Command, status and keyboard-byte signals between the host controller and its neighbours.
// master = command issuer / decoder side, slave = the controller.
interface ps2_host_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       done;
  logic [1:0] status;
  logic [7:0] rx_code;
  logic       rx_strobe;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_valid;

  modport master (
    output cmd_valid, cmd_data, rx_code, rx_strobe, rx_err,
    input  cmd_ready, done, status, key_code, key_valid
  );

  modport slave (
    input  cmd_valid, cmd_data, rx_code, rx_strobe, rx_err,
    output cmd_ready, done, status, key_code, key_valid
  );
endinterface

// File: rtl/ps2_host_ctrl_clk_filter.sv
// Two-flop synchroniser for both PS/2 pins plus a debounced clock with a one-cycle fall pulse.
// Filtered clock follows the pin only after DEB_LEN consecutive differing samples.
module ps2_clk_filter #(
  parameter int DEB_LEN = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic clk_pin,
  input  logic data_pin,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(DEB_LEN + 1);

  logic [1:0]    clk_meta;
  logic [1:0]    dat_meta;
  logic          clk_filt;
  logic [CW-1:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_meta <= 2'b11;
      dat_meta <= 2'b11;
      clk_filt <= 1'b1;
      deb_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      clk_meta <= {clk_meta[0], clk_pin};
      dat_meta <= {dat_meta[0], data_pin};
      fall     <= 1'b0;
      if (clk_meta[1] == clk_filt) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CW'(DEB_LEN - 1)) begin
        clk_filt <= clk_meta[1];
        deb_cnt  <= '0;
        fall     <= clk_filt;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign data_sync = dat_meta[1];

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host sequencer: inhibits the bus, clocks out a command byte, checks ack, awaits 0xFA/0xFE.
// Accepts a command only in IDLE (cmd_ready); other received bytes are forwarded as key_code.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 2500,
  parameter int TIMEOUT_CYC = 500000,
  parameter int MAX_RETRY   = 3,
  parameter int DEB_LEN     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  ps2_host_ctrl_if.slave    bus,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  output logic              ps2_clk_low,
  output logic              ps2_data_low
);

  localparam int TMAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  logic data_sync;
  logic fall;

  ps2_clk_filter #(.DEB_LEN(DEB_LEN)) u_clk_filter (
    .clk       (clk),
    .resetn    (resetn),
    .clk_pin   (ps2_clk_in),
    .data_pin  (ps2_data_in),
    .data_sync (data_sync),
    .fall      (fall)
  );

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic [7:0]    cmd_byte;
  logic [9:0]    shift;
  logic [3:0]    bit_idx;
  status_t       status_r;
  logic          done_r;
  logic [7:0]    key_code_r;
  logic          key_valid_r;

  logic    start, finish, forward, retry_inc;
  status_t fin_status;
  logic    timeout, inhibit_end, resp_ack, resp_bad;

  assign timeout     = (timer == TW'(TIMEOUT_CYC - 1));
  assign inhibit_end = (timer == TW'(INHIBIT_CYC - 1));
  assign resp_ack    = bus.rx_strobe && (bus.rx_code == ACK);
  assign resp_bad    = (bus.rx_strobe && (bus.rx_code == RESEND)) || bus.rx_err;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    finish     = 1'b0;
    fin_status = ST_OK;
    forward    = 1'b0;
    retry_inc  = 1'b0;
    case (state)
      IDLE: begin
        forward = bus.rx_strobe;
        if (bus.cmd_valid) begin
          start     = 1'b1;
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inhibit_end) state_nxt = REQ;
      end
      REQ: state_nxt = SEND;
      SEND: begin
        if (fall && bit_idx == 4'd9) begin
          state_nxt = ACKBIT;
        end else if (!fall && timeout) begin
          finish     = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      ACKBIT: begin
        if (fall) begin
          if (!data_sync) begin
            state_nxt = WAIT_RESP;
          end else begin
            finish     = 1'b1;
            fin_status = ST_NOACK;
          end
        end else if (timeout) begin
          finish     = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      WAIT_RESP: begin
        if (resp_ack) begin
          finish = 1'b1;
        end else if (resp_bad) begin
          if (retry < RW'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_nxt = INHIBIT;
          end else begin
            finish     = 1'b1;
            fin_status = ST_NACK;
          end
        end else if (bus.rx_strobe) begin
          forward = 1'b1;
        end else if (timeout && !fall) begin
          finish     = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (finish) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer        <= '0;
      retry        <= '0;
      cmd_byte     <= '0;
      shift        <= '0;
      bit_idx      <= '0;
      status_r     <= ST_OK;
      done_r       <= 1'b0;
      key_code_r   <= '0;
      key_valid_r  <= 1'b0;
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
    end else begin
      done_r      <= finish;
      key_valid_r <= forward;
      if (forward) key_code_r <= bus.rx_code;
      if (finish)  status_r   <= fin_status;

      if (start)          cmd_byte <= bus.cmd_data;
      if (start)          retry    <= '0;
      else if (retry_inc) retry    <= retry + 1'b1;

      // REQ and SEND share one timeout window, measured from the request-to-send.
      // Falls during INHIBIT are our own clock hold, so they must not restart the count.
      if (state == IDLE)
        timer <= '0;
      else if (state_nxt != state && state_nxt != SEND)
        timer <= '0;
      else if (fall && state != INHIBIT)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      if (state == REQ) begin
        shift   <= tx_frame(cmd_byte);
        bit_idx <= '0;
      end else if (state == SEND && fall) begin
        bit_idx <= bit_idx + 1'b1;
      end

      if (state_nxt == IDLE) begin
        ps2_clk_low  <= 1'b0;
        ps2_data_low <= 1'b0;
      end else if (state_nxt == INHIBIT) begin
        ps2_clk_low  <= 1'b1;
        ps2_data_low <= 1'b0;
      end else if (state_nxt == REQ) begin
        ps2_clk_low  <= 1'b0;
        ps2_data_low <= 1'b1;
      end else if (state == SEND && fall) begin
        ps2_data_low <= ~shift[bit_idx];
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = done_r;
  assign bus.status    = status_r;
  assign bus.key_code  = key_code_r;
  assign bus.key_valid = key_valid_r;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Randomised scoreboard bench for ps2_host_ctrl with a PS/2 device model and outcome reference model.
module tb_ps2_host_ctrl;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int DEB  = 4;
  localparam int MRT  = 2;
  localparam int HALF = 15;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_host_ctrl_if bus();
  logic ps2_clk_low, ps2_data_low;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_pin, ps2_data_pin;
  assign ps2_clk_pin  = ~(ps2_clk_low | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_low | dev_data_low);

  ps2_host_ctrl #(
    .INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MRT), .DEB_LEN(DEB)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .ps2_clk_in   (ps2_clk_pin),
    .ps2_data_in  (ps2_data_pin),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low)
  );

  int compared = 0;
  int mismatched = 0;
  int unsigned cyc = 0;
  int unsigned last_done_cyc = 0;
  int done_seen = 0, key_seen = 0, key_pushed = 0, inhibits = 0;
  bit mon_on = 1'b0;
  logic prev_cl = 1'b0;

  logic [1:0]  exp_done_q[$];
  logic [7:0]  exp_key_q[$];
  logic [10:0] exp_frame_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents done or key_valid.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.done) begin
        done_seen++;
        last_done_cyc = cyc;
        if (exp_done_q.size() == 0) flag("unexpected_done");
        else check("done_status", bus.status, exp_done_q.pop_front());
        check("lines_at_done", {ps2_clk_low, ps2_data_low, bus.cmd_ready}, 3'b001);
      end
      if (bus.key_valid) begin
        key_seen++;
        if (exp_key_q.size() == 0) flag("unexpected_key_valid");
        else check("key_code", bus.key_code, exp_key_q.pop_front());
      end
    end
    if (ps2_clk_low && !prev_cl) inhibits++;
    prev_cl = ps2_clk_low;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: number of transmissions and final status from the count of rejections.
  task automatic model(input int nfe, output int tx, output logic [1:0] st);
    tx = ((nfe > MRT) ? MRT : nfe) + 1;
    st = (nfe > MRT) ? 2'd1 : 2'd0;
  endtask

  // Line bits as a device sees them: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_bits(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic pulse_rx(input logic [7:0] code, input bit err);
    @(negedge clk);
    bus.rx_code   = code;
    bus.rx_strobe = !err;
    bus.rx_err    = err;
    @(negedge clk);
    bus.rx_strobe = 1'b0;
    bus.rx_err    = 1'b0;
  endtask

  task automatic issue(input logic [7:0] cmd);
    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_data  = cmd;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("cmd_ready_busy", bus.cmd_ready, 0);
  endtask

  task automatic wait_rts(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!(ps2_data_low && !ps2_clk_low)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        ok = 1'b0;
        flag("rts_wait: no request-to-send");
        break;
      end
    end
  endtask

  task automatic dev_frame(input bit ack, input bit inject_rx, output logic [10:0] bits);
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_data_pin;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      bits[i] = ps2_data_pin;
      dev_clk_low = 1'b0;
      if (inject_rx && i == 5) pulse_rx(8'h1C, 1'b0);
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = ack;
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    dev_data_low = 1'b0;
    repeat (HALF - 3) @(negedge clk);
  endtask

  task automatic check_frame(input logic [10:0] bits);
    if (exp_frame_q.size() == 0) flag("unexpected_frame");
    else check("frame_bits", bits, exp_frame_q.pop_front());
  endtask

  task automatic wait_done(input int d0, input int bound);
    int n = 0;
    while (done_seen == d0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_seen == d0) begin
      compared++;
      mismatched++;
      $display("FAIL done_wait: no done within %0d cycles", bound);
    end
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input int nfe, input bit use_err,
                         input bit stray, input logic [7:0] stray_code,
                         input bit inject_send_rx, input bit busy_cmd);
    int tx, inh0, d0;
    logic [1:0] st;
    logic [10:0] bits;
    bit ok;
    model(nfe, tx, st);
    exp_done_q.push_back(st);
    for (int t = 0; t < tx; t++) exp_frame_q.push_back(exp_bits(cmd));
    inh0 = inhibits;
    d0   = done_seen;
    issue(cmd);
    for (int t = 0; t < tx; t++) begin
      wait_rts(ok);
      if (!ok) break;
      dev_frame(1'b1, inject_send_rx && t == 0, bits);
      check_frame(bits);
      repeat (10) @(negedge clk);
      if (busy_cmd && t == 0) begin
        bus.cmd_data  = CMD_RESET;
        bus.cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.cmd_valid = 1'b0;
      end
      if (stray && t == tx - 1) begin
        exp_key_q.push_back(stray_code);
        key_pushed++;
        pulse_rx(stray_code, 1'b0);
        repeat (5) @(negedge clk);
      end
      if (t < nfe) begin
        if (use_err && $urandom_range(0, 1) == 1) pulse_rx(8'h00, 1'b1);
        else pulse_rx(RESEND, 1'b0);
      end else begin
        pulse_rx(ACK, 1'b0);
      end
    end
    wait_done(d0, 50);
    check("inhibit_phases", inhibits - inh0, tx);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b, sc;
    int d0;
    int unsigned t0;
    logic [10:0] bits;
    bit ok;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rx_code   = '0;
    bus.rx_strobe = 1'b0;
    bus.rx_err    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_done_status", {bus.done, bus.status}, 0);
    check("reset_key", {bus.key_valid, bus.key_code}, 0);
    check("reset_lines", {ps2_clk_low, ps2_data_low}, 0);
    resetn = 1'b1;
    mon_on = 1'b1;
    repeat (5) @(negedge clk);

    // Bytes arriving in IDLE are forwarded; an rx_err there is not.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_key_q.push_back(b);
      key_pushed++;
      pulse_rx(b, 1'b0);
    end
    pulse_rx(8'h55, 1'b1);
    repeat (5) @(negedge clk);

    run_cmd(CMD_LEDS, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_cmd(CMD_RESET, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h5A, 3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h12, 0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1);

    // Device never clocks.
    exp_done_q.push_back(2'd2);
    d0 = done_seen;
    issue(8'($urandom));
    t0 = 0;
    for (int n = 0; n < 500 && !ps2_data_low; n++) @(negedge clk);
    t0 = cyc;
    wait_done(d0, TMO + 100);
    check("timeout_latency", last_done_cyc - t0, TMO);
    repeat (5) @(negedge clk);

    // Device leaves data high on the ack bit.
    exp_done_q.push_back(2'd3);
    exp_frame_q.push_back(exp_bits(8'hF3));
    d0 = done_seen;
    issue(8'hF3);
    wait_rts(ok);
    if (ok) begin
      dev_frame(1'b0, 1'b0, bits);
      check_frame(bits);
    end
    wait_done(d0, 5);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do sc = 8'($urandom); while (sc == ACK || sc == RESEND);
      run_cmd(8'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)), sc,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of SEND.
    d0 = done_seen;
    issue(8'hA5);
    wait_rts(ok);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("pre_reset_busy", {bus.cmd_ready, ps2_data_low}, 2'b00 | {1'b0, ps2_data_low});
    resetn = 1'b0;
    @(negedge clk);
    check("reset_midsend_lines", {ps2_clk_low, ps2_data_low, bus.cmd_ready, bus.done}, 4'b0010);
    check("reset_midsend_status", bus.status, 0);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    check("no_done_after_reset", done_seen - d0, 0);

    check("key_count", key_seen, key_pushed);
    check("done_queue_drained", exp_done_q.size(), 0);
    check("key_queue_drained", exp_key_q.size(), 0);
    check("frame_queue_drained", exp_frame_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
Host-side sequencer for the PS/2 keyboard port. It shares the bidirectional open-drain PS/2 lines between the receive-only keyboard decoder and a host-to-device command path, used for reset (0xFF) and LED set (0xED, mask). It inhibits the bus, clocks out one command byte, checks the device ack bit, and waits for the 0xFA/0xFE response byte from the decoder. Received bytes that are not command responses are forwarded to the keyboard consumer.

Parameters:
INHIBIT_CYC, 2500, cycles ps2 clock is held low before request-to-send (100 us at 25 MHz)
TIMEOUT_CYC, 500000, max cycles waited for any device clock edge or response byte (20 ms at 25 MHz)
MAX_RETRY, 3, resends allowed after 0xFE or a receive error
DEB_LEN, 8, cycles ps2_clk_in must be stable for a level to be accepted

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active low
cmd_valid  in  1  command byte offered
cmd_data  in  8  command byte
cmd_ready  out  1  high only in IDLE; transfer when cmd_valid&&cmd_ready
done  out  1  one-cycle pulse when a command finishes
status  out  2  valid with done: 0 ok, 1 nack retries exhausted, 2 timeout, 3 ack bit missing
rx_code  in  8  byte from keyboard decoder
rx_strobe  in  1  decoder byte-valid pulse
rx_err  in  1  decoder frame/parity error pulse
key_code  out  8  forwarded byte
key_valid  out  1  one-cycle forward pulse
ps2_clk_in  in  1  raw ps2 clock pin level
ps2_data_in  in  1  raw ps2 data pin level
ps2_clk_low  out  1  1 = drive clock pin low (open drain)
ps2_data_low  out  1  1 = drive data pin low (open drain)

Behaviour:
- Reset: state IDLE; cmd_ready=1, done=0, status=0, key_valid=0, key_code=0, ps2_clk_low=0, ps2_data_low=0, retry=0, counters=0. A reset mid-transfer releases both lines in the next cycle.
- Pin inputs use a 2-flop sync. Filtered clock changes level after DEB_LEN equal samples. fall = filtered 1->0 transition, a one-cycle pulse.
- IDLE: rx_strobe forwards as key_code<=rx_code with key_valid pulse. On accept, latch byte, clear retry, go to INHIBIT.
- INHIBIT: clk_low=1 for INHIBIT_CYC cycles, then go to REQ.
- REQ: data_low=1, clk_low=0. Shift register <= {1 stop, odd parity, data[7:0]}, bit=0, timer=0. Go to SEND.
- SEND: on each fall, data_low <= ~shift[bit], bit++. Start bit is already on the line. After 10 falls (8 data, parity, stop=released), go to ACKBIT.
- ACKBIT: on next fall, sample data. 0 -> WAIT_RESP. 1 -> done with status 3.
- WAIT_RESP: rx_strobe with 0xFA -> done, status 0. 0xFE or rx_err -> if retry<MAX_RETRY then retry++ and go to INHIBIT, else done with status 1. Any other byte is forwarded and waiting continues.
- Timeout: timer clears on every fall and on state entry. If it reaches TIMEOUT_CYC in SEND, ACKBIT or WAIT_RESP -> release lines, done, status 2.
- rx_strobe and rx_err are ignored, not forwarded, in INHIBIT, REQ, SEND and ACKBIT.
- DONE is transient: the done pulse fires on the cycle of return to IDLE. The lines are already released and cmd_ready rises in the same cycle.
- cmd_valid while busy is ignored (cmd_ready=0).
- status holds its value until the next done.

Decomposition:
- Shared package ps2_pkg: state enum (IDLE, INHIBIT, REQ, SEND, ACKBIT, WAIT_RESP), status codes ST_OK/ST_NACK/ST_TIMEOUT/ST_NOACK, and byte constants ACK=8'hFA, RESEND=8'hFE, CMD_RESET=8'hFF, CMD_LEDS=8'hED.
- One sub-module: ps2_clk_filter (sync, debounce, fall pulse).

Test Plan:
- Bench params: INHIBIT_CYC=20, TIMEOUT_CYC=2000, DEB_LEN=4, MAX_RETRY=2.
- Send 0xED with the device model clocking 11 edges, data low on the ack bit, then rx 0xFA -> bits observed LSB-first 1,0,1,1,0,1,1,1, parity 1, stop released; done, status 0.
- Device returns 0xFE twice, then 0xFA -> exactly 3 inhibit phases; done, status 0. Always 0xFE -> 3 transmissions, then done, status 1.
- Device never clocks -> done, status 2 exactly TIMEOUT_CYC cycles after REQ entry; both lines released.
- Device leaves data high on the ack bit -> done, status 3, no wait for a response.
- In WAIT_RESP, rx 0x1C then 0xFA -> key_valid once with 0x1C, then done, status 0. rx_strobe during SEND -> no key_valid.
- resetn low during SEND -> next cycle ps2_clk_low=0, ps2_data_low=0, cmd_ready=1, no done.
